// File: rtl/flip_sequencer.sv
// Turn controller for the tile-flip memory game: switch edges become tile flips,
// each two-flip turn is compared, mismatches are held on screen, solved tiles accumulate.
module flip_sequencer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned TRIES_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        switches,
  input  logic [47:0]        tile_values,
  output logic [15:0]        revealed,
  output logic [15:0]        matched_tiles,
  output logic [15:0]        mismatched_tiles,
  output logic [TRIES_W-1:0] tries,
  output logic               busy,
  output logic               game_won
);

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StWait1, StWait2, StCompare, StShowMiss, StWon
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         sw_prev_q, sw_prev_d;
  logic [47:0]         vals_q, vals_d;
  logic [3:0]          first_idx_q, first_idx_d;
  logic [3:0]          second_idx_q, second_idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [15:0]         revealed_q, revealed_d;
  logic [15:0]         matched_q, matched_d;
  logic [15:0]         mismatched_q, mismatched_d;
  logic [TRIES_W-1:0]  tries_q, tries_d;
  logic                req_vld_q, req_vld_d;
  logic [3:0]          req_idx_q, req_idx_d;

  logic [15:0] rise;
  logic        req_hit;
  logic [3:0]  req_pick;
  logic        req_ok;
  logic [5:0]  first_base, second_base;
  logic [2:0]  val_first, val_second;
  logic [15:0] pair_mask;

  always_comb begin
    rise     = switches & ~sw_prev_q & ~matched_q & ~revealed_q;
    req_hit  = 1'b0;
    req_pick = 4'd0;
    // Descending scan so the lowest set index wins.
    for (int i = 15; i >= 0; i--) begin
      if (rise[i]) begin
        req_hit  = 1'b1;
        req_pick = 4'(i);
      end
    end
  end

  always_comb begin
    first_base  = 6'(first_idx_q) * 6'd3;
    second_base = 6'(second_idx_q) * 6'd3;
    val_first   = vals_q[first_base +: 3];
    val_second  = vals_q[second_base +: 3];
    pair_mask   = (16'h1 << first_idx_q) | (16'h1 << second_idx_q);
    // The request was captured a cycle ago; re-check the tile is still face-down.
    req_ok      = req_vld_q && !revealed_q[req_idx_q] && !matched_q[req_idx_q];
  end

  always_comb begin
    state_d      = state_q;
    sw_prev_d    = switches;
    vals_d       = vals_q;
    first_idx_d  = first_idx_q;
    second_idx_d = second_idx_q;
    cnt_d        = cnt_q;
    revealed_d   = revealed_q;
    matched_d    = matched_q;
    mismatched_d = mismatched_q;
    tries_d      = tries_q;
    req_vld_d    = req_hit && ((state_q == StWait1) || (state_q == StWait2));
    req_idx_d    = req_pick;

    if (start) begin
      state_d      = StWait1;
      vals_d       = tile_values;
      cnt_d        = '0;
      revealed_d   = '0;
      matched_d    = '0;
      mismatched_d = '0;
      tries_d      = '0;
      req_vld_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StWait1: begin
          if (req_ok) begin
            revealed_d[req_idx_q] = 1'b1;
            first_idx_d           = req_idx_q;
            state_d               = StWait2;
          end
        end
        StWait2: begin
          if (req_ok) begin
            revealed_d[req_idx_q] = 1'b1;
            second_idx_d          = req_idx_q;
            state_d               = StCompare;
          end
        end
        StCompare: begin
          if (!(&tries_q)) tries_d = tries_q + TRIES_W'(1);
          if (val_first == val_second) begin
            matched_d  = matched_q | pair_mask;
            revealed_d = revealed_q & ~pair_mask;
            state_d    = (matched_d == 16'hFFFF) ? StWon : StWait1;
          end else begin
            mismatched_d = pair_mask;
            cnt_d        = HoldLoad;
            state_d      = StShowMiss;
          end
        end
        StShowMiss: begin
          if (cnt_q == '0) begin
            revealed_d   = revealed_q & ~pair_mask;
            mismatched_d = '0;
            state_d      = StWait1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StWon: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      sw_prev_q    <= '0;
      vals_q       <= '0;
      first_idx_q  <= '0;
      second_idx_q <= '0;
      cnt_q        <= '0;
      revealed_q   <= '0;
      matched_q    <= '0;
      mismatched_q <= '0;
      tries_q      <= '0;
      req_vld_q    <= 1'b0;
      req_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      sw_prev_q    <= sw_prev_d;
      vals_q       <= vals_d;
      first_idx_q  <= first_idx_d;
      second_idx_q <= second_idx_d;
      cnt_q        <= cnt_d;
      revealed_q   <= revealed_d;
      matched_q    <= matched_d;
      mismatched_q <= mismatched_d;
      tries_q      <= tries_d;
      req_vld_q    <= req_vld_d;
      req_idx_q    <= req_idx_d;
    end
  end

  assign revealed         = revealed_q;
  assign matched_tiles    = matched_q;
  assign mismatched_tiles = mismatched_q;
  assign tries            = tries_q;
  assign busy             = (state_q == StCompare) || (state_q == StShowMiss);
  assign game_won         = (state_q == StWon);

endmodule

// File: tb/tb_flip_sequencer.sv
// Scoreboard bench for flip_sequencer: a game-rule model predicts every cycle's outputs,
// a negedge monitor pops and compares. A second instance with a 2-bit try counter checks saturation.
module tb_flip_sequencer;

  localparam int unsigned Hold = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] sw = '0;
  logic [47:0] tv = '0;

  logic [15:0] d_rev, d_mat, d_mis;
  logic [7:0]  d_tries;
  logic        d_busy, d_won;
  logic [15:0] s_rev, s_mat, s_mis;
  logic [1:0]  s_tries;
  logic        s_busy, s_won;

  always #5 clk = ~clk;

  flip_sequencer #(.HOLD_CYCLES(Hold), .TRIES_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .switches(sw), .tile_values(tv),
    .revealed(d_rev), .matched_tiles(d_mat), .mismatched_tiles(d_mis),
    .tries(d_tries), .busy(d_busy), .game_won(d_won)
  );

  flip_sequencer #(.HOLD_CYCLES(Hold), .TRIES_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .switches(sw), .tile_values(tv),
    .revealed(s_rev), .matched_tiles(s_mat), .mismatched_tiles(s_mis),
    .tries(s_tries), .busy(s_busy), .game_won(s_won)
  );

  typedef struct {
    logic [15:0] rev, mat, mis;
    logic [7:0]  tr8;
    logic [1:0]  tr2;
    logic        busy, won;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: 0 idle, 1 awaiting first flip, 2 awaiting second, 3 judging, 4 showing miss, 5 won
  int m_phase = 0;
  bit m_prev[16];
  int m_vals[16];
  bit m_rev[16];
  bit m_mat[16];
  bit m_mis[16];
  int m_first, m_second, m_hold, m_tries, m_pend;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_rev[i] = 0; m_mat[i] = 0; m_mis[i] = 0;
    end
    m_tries = 0; m_hold = 0; m_pend = -1;
  endtask

  task automatic model_step();
    int  new_pend;
    bool_all: begin end
    if (reset) begin
      model_clear();
      for (int i = 0; i < 16; i++) m_prev[i] = 0;
      m_phase = 0;
      return;
    end
    new_pend = -1;
    if (m_phase == 1 || m_phase == 2) begin
      for (int i = 0; i < 16; i++) begin
        if (new_pend < 0 && sw[i] && !m_prev[i] && !m_rev[i] && !m_mat[i]) new_pend = i;
      end
    end
    for (int i = 0; i < 16; i++) m_prev[i] = sw[i];
    if (start) begin
      model_clear();
      for (int i = 0; i < 16; i++) m_vals[i] = int'(tv[3*i +: 3]);
      m_phase = 1;
      return;
    end
    case (m_phase)
      1, 2: begin
        if (m_pend >= 0 && !m_rev[m_pend] && !m_mat[m_pend]) begin
          m_rev[m_pend] = 1;
          if (m_phase == 1) begin m_first = m_pend; m_phase = 2; end
          else begin m_second = m_pend; m_phase = 3; end
        end
      end
      3: begin
        int solved;
        m_tries++;
        if (m_vals[m_first] == m_vals[m_second]) begin
          m_mat[m_first] = 1; m_mat[m_second] = 1;
          m_rev[m_first] = 0; m_rev[m_second] = 0;
          solved = 0;
          for (int i = 0; i < 16; i++) solved += m_mat[i];
          m_phase = (solved == 16) ? 5 : 1;
        end else begin
          m_mis[m_first] = 1; m_mis[m_second] = 1;
          m_hold = Hold;
          m_phase = 4;
        end
      end
      4: begin
        m_hold--;
        if (m_hold == 0) begin
          m_rev[m_first] = 0; m_rev[m_second] = 0;
          m_mis[m_first] = 0; m_mis[m_second] = 0;
          m_phase = 1;
        end
      end
      default: ;
    endcase
    m_pend = new_pend;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.rev[i] = m_rev[i]; e.mat[i] = m_mat[i]; e.mis[i] = m_mis[i];
    end
    e.tr8  = 8'((m_tries > 255) ? 255 : m_tries);
    e.tr2  = 2'((m_tries > 3) ? 3 : m_tries);
    e.busy = (m_phase == 3) || (m_phase == 4);
    e.won  = (m_phase == 5);
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("revealed", d_rev, e.rev);
      check("matched_tiles", d_mat, e.mat);
      check("mismatched_tiles", d_mis, e.mis);
      check("tries", 16'(d_tries), 16'(e.tr8));
      check("tries_sat", 16'(s_tries), 16'(e.tr2));
      check("busy", 16'(d_busy), 16'(e.busy));
      check("game_won", 16'(d_won), 16'(e.won));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    sb.push_back(model_out());
    #1;
  endtask

  task automatic flip(input int i);
    sw[i] = 1'b1; tick();
    sw[i] = 1'b0; tick();
  endtask

  task automatic do_start(input logic [47:0] vals);
    tv = vals; start = 1'b1; tick(); start = 1'b0;
  endtask

  logic [47:0] pairs;

  initial begin
    for (int i = 0; i < 16; i++) pairs[3*i +: 3] = 3'(i >> 1);

    // Reset with switches high, then pulses in idle do nothing.
    sw = 16'hFFFF; tick(); tick();
    reset = 1'b0; sw = '0; tick();
    sw = 16'h00FF; tick(); sw = '0; tick(); tick();
    check("idle_revealed", d_rev, 16'h0000);

    // Matching pair.
    do_start(pairs);
    flip(0);
    check("first_reveal", d_rev, 16'h0001);
    flip(1);
    check("second_reveal", d_rev, 16'h0003);
    tick();
    check("match_mask", d_mat, 16'h0003);
    check("match_tries", 16'(d_tries), 16'd1);

    // Mismatch held for Hold cycles; sw4 during hold is ignored.
    do_start(pairs);
    flip(0); flip(2); tick();
    check("miss_mask", d_mis, 16'h0005);
    sw[4] = 1'b1; tick(); sw[4] = 1'b0; tick(); tick(); tick();
    check("miss_cleared", d_rev, 16'h0000);
    check("miss_tries", 16'(d_tries), 16'd1);

    // Simultaneous edges and re-flips.
    sw = 16'h0028; tick(); sw = '0; tick();
    check("lowest_edge", d_rev, 16'h0008);
    flip(3);
    check("reflip_ignored", d_rev, 16'h0008);
    flip(2); tick();
    flip(3);
    check("matched_reflip", d_rev, 16'h0000);

    // Full win then restart.
    do_start(pairs);
    for (int p = 0; p < 8; p++) begin
      flip(2 * p); flip(2 * p + 1); tick();
    end
    check("won_flag", 16'(d_won), 16'd1);
    check("won_mask", d_mat, 16'hFFFF);
    do_start(pairs); tick();
    check("restart_mask", d_mat, 16'h0000);

    // Saturation on the narrow counter, then reset mid-hold.
    for (int t = 0; t < 5; t++) begin
      flip(0); flip(2); repeat (Hold + 1) tick();
    end
    check("sat_tries", 16'(s_tries), 16'd3);
    flip(0); flip(2); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("reset_mid_hold", d_mis, 16'h0000);

    // Randomized play.
    do_start({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 1) sw[$urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) sw = '0;
      start = ($urandom_range(0, 149) == 0);
      reset = ($urandom_range(0, 499) == 0);
      if (start) tv = ($urandom_range(0, 1) == 1) ? pairs : {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      tick();
    end
    start = 1'b0; reset = 1'b0;

    repeat (2) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flip_sequencer.md
# flip_sequencer

Turn controller for the tile-flip memory game. Sits between the debounced switch bank and the VGA driver: it takes the shuffled tile-value array, turns switch rising edges into tile flips, sequences each two-flip turn (reveal, compare, hold a mismatch on screen, hide), and produces the `matched_tiles` / `mismatched_tiles` / revealed masks, try count and win flag that the display and LEDs consume.

## Interface
- `HOLD_CYCLES`, 50_000_000: cycles a mismatched pair stays revealed (1 s at 50 MHz); must be ≥ 1.
- `TRIES_W`, 8: width of the try counter.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `start` in 1: one-cycle pulse; begins a new game and samples `tile_values`.
- `switches` in 16: debounced switches; bit i flips tile i.
- `tile_values` in 48: tile i value at [3i+2:3i], from the array shuffler.
- `revealed` out 16: tiles currently face-up but not matched.
- `matched_tiles` out 16: tiles permanently solved.
- `mismatched_tiles` out 16: the pair being shown as wrong; nonzero only in SHOW_MISS.
- `tries` out TRIES_W: completed turns, saturating.
- `busy` out 1: high in COMPARE and SHOW_MISS (flips ignored).
- `game_won` out 1: high in WON.

## Operation
- Internal: `sw_prev[15:0]` loaded with `switches` every non-reset cycle; `vals[47:0]` latched copy of `tile_values`; `first_idx[3:0]`, `second_idx[3:0]`; hold counter sized for HOLD_CYCLES.
- Flip request: `rise = switches & ~sw_prev & ~matched_tiles & ~revealed`. If several bits are set, the lowest index is taken; the rest are dropped (not queued). Edges outside WAIT1/WAIT2 are dropped.
- States:
  - IDLE: all outputs 0. `start` -> WAIT1.
  - WAIT1: on a request for tile i, set `revealed[i]`, `first_idx`<=i, -> WAIT2.
  - WAIT2: on a request for tile j, set `revealed[j]`, `second_idx`<=j, -> COMPARE.
  - COMPARE (1 cycle): `tries` += 1, saturating at all-ones. If the values are equal, set both `matched_tiles` bits and clear both `revealed` bits; then -> WON if `matched_tiles` becomes 16'hFFFF, else -> WAIT1. If they differ, set both `mismatched_tiles` bits, load the counter, -> SHOW_MISS.
  - SHOW_MISS: count HOLD_CYCLES cycles. On the last one, clear both `revealed` and both `mismatched_tiles` bits, -> WAIT1.
  - WON: hold all outputs until `start` or `reset`.
- `start` in any state: clear `revealed`/`matched_tiles`/`mismatched_tiles`/`tries` and counter, latch `vals`, -> WAIT1 next cycle. `start` has priority over every other event in that cycle, including a flip edge.
- `reset` overrides `start`. A mid-turn or mid-hold reset returns to IDLE with all outputs 0 on the next edge.
- Value compare uses the latched `vals`; later changes on `tile_values` have no effect until the next `start`.

## Timing
- Reset values: every output 0, state IDLE, `sw_prev` 0.
- Edge detect: `switches[i]` 0->1 sampled at edge t (with `sw_prev[i]`=0) -> `revealed[i]`=1 after edge t+1.
- Second flip accepted at edge t: COMPARE during t+1. After edge t+2: `tries` updated; match/mismatch bits valid; state WAIT1, WON or SHOW_MISS.
- Mismatch: `mismatched_tiles` high for exactly HOLD_CYCLES cycles. `busy` is high from the COMPARE cycle to the end of the hold. A new flip is accepted from the first WAIT1 cycle after that.
- `game_won` rises on the edge after the final COMPARE, i.e. 2 cycles after the last flip is accepted.
- A held switch produces no repeat flips. It must return to 0 before it can flip that tile again.

## Test plan
- Reset/idle: assert reset 2 cycles with switches=16'hFFFF, then pulse switches in IDLE -> all outputs stay 0, no flips.
- Match: start with tile i value = i>>1; raise sw0, then sw1 -> `revealed` 0x0001 then 0x0003; 2 cycles later `matched_tiles`=0x0003, `revealed`=0, `tries`=1.
- Mismatch, HOLD_CYCLES=4: flip tiles 0 and 2 -> `mismatched_tiles`=0x0005 for exactly 4 cycles, `busy`=1; sw4 rising during the hold is ignored; afterwards `revealed`=0 and `tries`=1.
- Simultaneous/illegal edges: sw3 and sw5 rise in the same cycle -> only tile 3 revealed. Re-flipping tile 3 or a matched tile -> ignored, state unchanged.
- Win and restart: solve all 8 pairs in 8 turns -> `game_won`=1, `tries`=8, `matched_tiles`=0xFFFF. Then pulse `start` -> everything clears, WAIT1.
- Saturation/mid-op: with TRIES_W=2, play 5 mismatching turns -> `tries`=3. Reset during SHOW_MISS -> all outputs 0 on the next cycle.
